// File: rtl/audio_pkg.sv
// Shared audio constants and the sample-queue burst FSM encoding.
// The FIR filter bank reuses FILT_TAPS so both blocks agree on window length.
package audio_pkg;
  localparam int QUEUE_DEPTH = 1024;
  localparam int FILT_TAPS   = 1021;
  localparam int SMPL_W      = 16;

  typedef enum logic [1:0] {IDLE, LOAD, SEQ} seq_state_e;
endpackage

// File: rtl/dp_ram_1024x32.sv
// Simple dual-port RAM: one write port, one synchronous read port.
// The array is not reset; only the read-data register clears on reset.
module dp_ram_1024x32 #(
  parameter int DEPTH = 1024,
  parameter int WIDTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_re,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);
  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Read register doubles as the burst output register, so it holds when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    o_rdata <= '0;
    else if (i_re) o_rdata <= r_mem[i_raddr];
  end
endmodule

// File: rtl/smpl_queue.sv
// Circular stereo sample queue; replays the TAPS most recent samples,
// oldest first, as one TAPS-cycle burst per new sample once full.
module smpl_queue
  import audio_pkg::*;
#(
  parameter int DEPTH = QUEUE_DEPTH,
  parameter int TAPS  = FILT_TAPS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_new_smpl,
  input  logic [SMPL_W-1:0] i_lft_smpl,
  input  logic [SMPL_W-1:0] i_rght_smpl,
  output logic              o_sequencing,
  output logic [SMPL_W-1:0] o_lft_out,
  output logic [SMPL_W-1:0] o_rght_out
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(TAPS + 1);
  localparam logic [CW-1:0] LAST_TAP = CW'(TAPS - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(TAPS);

  seq_state_e          r_state, w_nxt;
  logic [AW-1:0]       r_new_ptr, r_old_ptr, r_rd_ptr, w_raddr;
  logic [CW-1:0]       r_cnt, r_tap;
  logic                r_pend, r_seq, w_full, w_req, w_re;
  logic [2*SMPL_W-1:0] w_rdata;

  assign w_full = (r_cnt == FULL_CNT);
  // The write that completes the fill also requests the first burst.
  assign w_req  = i_new_smpl && (w_full || (r_cnt == LAST_TAP));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_new_ptr <= '0;
      r_old_ptr <= '0;
      r_cnt     <= '0;
    end else if (i_new_smpl) begin
      r_new_ptr <= r_new_ptr + AW'(1);
      if (w_full) r_old_ptr <= r_old_ptr + AW'(1);
      else        r_cnt     <= r_cnt + CW'(1);
    end
  end

  always_comb begin
    w_nxt   = r_state;
    w_re    = 1'b0;
    w_raddr = r_rd_ptr;
    case (r_state)
      IDLE: if (r_pend) w_nxt = LOAD;
      LOAD: begin
        w_nxt   = SEQ;
        w_re    = 1'b1;
        w_raddr = r_old_ptr;
      end
      SEQ: begin
        if (r_tap == LAST_TAP) w_nxt = IDLE;
        else                   w_re  = 1'b1;
      end
      default: w_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_pend   <= 1'b0;
      r_seq    <= 1'b0;
      r_rd_ptr <= '0;
      r_tap    <= '0;
    end else begin
      r_state <= w_nxt;
      r_seq   <= (w_nxt == SEQ);
      // A strobe during a burst leaves one request; IDLE consumes it.
      r_pend  <= w_req | (r_pend & (r_state != IDLE));
      if (r_state == LOAD) begin
        r_rd_ptr <= r_old_ptr + AW'(1);
        r_tap    <= '0;
      end else if (r_state == SEQ) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
        r_tap    <= r_tap + CW'(1);
      end
    end
  end

  dp_ram_1024x32 #(.DEPTH(DEPTH), .WIDTH(2*SMPL_W)) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (i_new_smpl),
    .i_waddr (r_new_ptr),
    .i_wdata ({i_lft_smpl, i_rght_smpl}),
    .i_re    (w_re),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  assign o_sequencing = r_seq;
  assign o_lft_out    = w_rdata[2*SMPL_W-1:SMPL_W];
  assign o_rght_out   = w_rdata[SMPL_W-1:0];
endmodule
